// File: rtl/fruit_launcher.sv
// fruit_launcher: trajectory commander for one flying object.
// Drives the position integrator's spawn point, speeds, directions, move
// strobe and reload pulse. Sequences spawn, ballistic flight with gravity,
// off-screen exit or slice termination, then respawns after an idle gap.
//
// Optional build macro: LAUNCHER_RANDOM_EN
//   defined   -> a 16-bit Fibonacci LFSR randomises the spawn x, the
//                horizontal direction, and the launch speeds.
//   undefined -> fixed launch parameters; no LFSR is built.
//
// Integrator protocol: objRst is a one-cycle reload strobe; the integrator
// loads initPosX/initPosY and latches vx/vy/dx/dy while objRst is high.
// moveclk is a one-cycle step strobe; the integrator takes one step using
// the vx/vy/dx/dy values present during that cycle. There is no
// back-pressure: every strobe is consumed.
//
// state_dbg encoding: 0 IDLE, 1 LAUNCH, 2 FLY, 3 DONE.
module fruit_launcher #(
  parameter int          TICK_DIV  = 1000000,
  parameter int          GRAV_DIV  = 4,
  parameter int          SPAWN_GAP = 50,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          VX_LAUNCH = 2,
  parameter int          VY_LAUNCH = 12,
  parameter int          VY_MAX    = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] posx,
  input  logic [8:0] posy,
  input  logic       sliced,
  output logic [9:0] initPosX,
  output logic [8:0] initPosY,
  output logic [9:0] vx,
  output logic [8:0] vy,
  output logic [1:0] dx,
  output logic [1:0] dy,
  output logic       moveclk,
  output logic       objRst,
  output logic       active,
  output logic       done,
  output logic       hit,
  output logic [1:0] state_dbg
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW  = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
  localparam int GRW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic [1:0] DIR_INC  = 2'b11;
  localparam logic [1:0] DIR_DEC  = 2'b10;
  localparam logic [1:0] DIR_HOLD = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FLY    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [TW-1:0]  tick_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [GRW-1:0] grav_cnt;
  logic           tick;
  logic           exit_hit;

  // launch parameters presented to the IDLE->LAUNCH transition
  logic [9:0] l_x;
  logic [9:0] l_vx;
  logic [8:0] l_vy;
  logic [1:0] l_dx;

  // 11-bit copies so the exit sums and compares cannot wrap
  logic [10:0] px_e, py_e, vx_e, vy_e;

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign state_dbg = state;

`ifdef LAUNCHER_RANDOM_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [9:0]  vx_launch_unused;

  // VX_LAUNCH is superseded by the random speed in this build
  assign vx_launch_unused = 10'(VX_LAUNCH);
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Free-running LFSR, taps 16,14,13,11, advances every clock
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Random launch parameters drawn from the current LFSR state
  always_comb begin
    l_x  = 10'd192 + {2'b00, lfsr[7:0]};
    l_dx = lfsr[8] ? DIR_INC : DIR_DEC;
    l_vx = 10'd1 + {8'd0, lfsr[10:9]};
    l_vy = 9'(VY_LAUNCH) - {7'd0, lfsr[12:11]};
  end
`else
  logic [15:0] lfsr_seed_unused;

  // The seed parameter stays in the parameter list so both builds match
  assign lfsr_seed_unused = LFSR_SEED;

  // Fixed launch parameters
  always_comb begin
    l_x  = 10'(SCREEN_W / 2);
    l_dx = DIR_INC;
    l_vx = 10'(VX_LAUNCH);
    l_vy = 9'(VY_LAUNCH);
  end
`endif

  // Off-screen exit test against the step about to be taken
  always_comb begin
    px_e     = {1'b0, posx};
    py_e     = {2'b00, posy};
    vx_e     = {1'b0, vx};
    vy_e     = {2'b00, vy};
    exit_hit = 1'b0;
    if ((dy == DIR_DEC) && (py_e < vy_e))                    exit_hit = 1'b1;
    if ((dy == DIR_INC) && ((py_e + vy_e) >= 11'(SCREEN_H))) exit_hit = 1'b1;
    if ((dx == DIR_DEC) && (px_e < vx_e))                    exit_hit = 1'b1;
    if ((dx == DIR_INC) && ((px_e + vx_e) >= 11'(SCREEN_W))) exit_hit = 1'b1;
  end

  // Next-state logic and state-decoded strobes
  always_comb begin
    state_n = state;
    objRst  = 1'b0;
    active  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        // the tick that takes the gap counter to zero starts the launch
        if (tick && (gap_cnt <= GW'(1))) state_n = LAUNCH;
      end
      LAUNCH: begin
        objRst  = 1'b1;
        state_n = FLY;
      end
      FLY: begin
        active = 1'b1;
        if (sliced || (tick && exit_hit)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Tick divider: free-running, restarted at launch so flight is phase-aligned
  always_ff @(posedge clk) begin
    if (rst)                           tick_cnt <= '0;
    else if ((state == LAUNCH) || tick) tick_cnt <= '0;
    else                               tick_cnt <= tick_cnt + 1'b1;
  end

  // Flight datapath: launch loading, strobes, gravity, termination
  always_ff @(posedge clk) begin
    if (rst) begin
      moveclk  <= 1'b0;
      hit      <= 1'b0;
      vx       <= '0;
      vy       <= '0;
      dx       <= DIR_HOLD;
      dy       <= DIR_HOLD;
      initPosX <= 10'(SCREEN_W / 2);
      initPosY <= 9'(SCREEN_H - 10);
      gap_cnt  <= GW'(SPAWN_GAP);
      grav_cnt <= '0;
    end else begin
      moveclk <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            if (gap_cnt <= GW'(1)) begin
              gap_cnt  <= '0;
              initPosX <= l_x;
              initPosY <= 9'(SCREEN_H - 10);
              vx       <= l_vx;
              vy       <= l_vy;
              dx       <= l_dx;
              dy       <= DIR_DEC;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
        end
        LAUNCH: begin
          grav_cnt <= '0;
          hit      <= 1'b0;
        end
        FLY: begin
          // gravity is applied after the strobe cycle so the integrator
          // steps with the speeds it saw while moveclk was high
          if (moveclk) begin
            if (grav_cnt == GRW'(GRAV_DIV - 1)) begin
              grav_cnt <= '0;
              if (dy == DIR_DEC) begin
                if (vy > 9'd1) vy <= vy - 9'd1;
                else           dy <= DIR_INC;
              end else begin
                if (vy >= 9'(VY_MAX)) vy <= 9'(VY_MAX);
                else                  vy <= vy + 9'd1;
              end
            end else begin
              grav_cnt <= grav_cnt + 1'b1;
            end
          end
          // termination overrides any gravity direction change above
          if (sliced) begin
            hit <= 1'b1;
            dx  <= DIR_HOLD;
            dy  <= DIR_HOLD;
          end else if (tick) begin
            if (exit_hit) begin
              hit <= 1'b0;
              dx  <= DIR_HOLD;
              dy  <= DIR_HOLD;
            end else begin
              moveclk <= 1'b1;
            end
          end
        end
        DONE: begin
          gap_cnt <= GW'(SPAWN_GAP);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_launcher.sv
// tb_fruit_launcher: scoreboard bench for fruit_launcher with
// TICK_DIV=4, GRAV_DIV=2, SPAWN_GAP=3. Expected launch/move/done events,
// each stamped with the cycle it must appear in, are queued by the
// stimulus; a monitor pops and compares on every objRst/moveclk/done.
module tb_fruit_launcher;

  localparam int W = 62;
  localparam logic [1:0] K_LAUNCH = 2'd1;
  localparam logic [1:0] K_MOVE   = 2'd2;
  localparam logic [1:0] K_DONE   = 2'd3;

  logic       clk;
  logic       rst;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       sliced;
  logic [9:0] initPosX;
  logic [8:0] initPosY;
  logic [9:0] vx;
  logic [8:0] vy;
  logic [1:0] dx;
  logic [1:0] dy;
  logic       moveclk;
  logic       objRst;
  logic       active;
  logic       done;
  logic       hit;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  logic [1:0]   mon_kind;

  // model state for expected events
  logic [9:0] m_x, m_vx;
  logic [8:0] m_y, m_vy;
  logic [1:0] m_dx, m_dy;
  logic       m_hit;
  int         m_grav;

  fruit_launcher #(
    .TICK_DIV (4),
    .GRAV_DIV (2),
    .SPAWN_GAP(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .posx     (posx),
    .posy     (posy),
    .sliced   (sliced),
    .initPosX (initPosX),
    .initPosY (initPosY),
    .vx       (vx),
    .vy       (vy),
    .dx       (dx),
    .dy       (dy),
    .moveclk  (moveclk),
    .objRst   (objRst),
    .active   (active),
    .done     (done),
    .hit      (hit),
    .state_dbg(state_dbg)
  );

  // clock and cycle stamp (cycle 0 = first cycle after the last reset edge)
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [W-1:0] pack(input logic [15:0] c, input logic [1:0] k,
                                         input logic [9:0] x, input logic [8:0] y,
                                         input logic [9:0] vx_v, input logic [8:0] vy_v,
                                         input logic [1:0] dx_v, input logic [1:0] dy_v,
                                         input logic h, input logic a);
    logic h_eff;
    h_eff = (k == K_LAUNCH) ? 1'b0 : h;
    return {c, k, x, y, vx_v, vy_v, dx_v, dy_v, h_eff, a};
  endfunction

  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      total++;
      bad++;
      $display("FAIL wait_cyc got=%0d want=%0d", cyc, target);
    end
  endtask

  // expected launch event; also seeds the flight model
  task automatic exp_launch(input int c);
`ifdef LAUNCHER_RANDOM_EN
    logic [15:0] l;
    l    = lfsr_at(c - 1);
    m_x  = 10'd192 + {2'b00, l[7:0]};
    m_dx = l[8] ? 2'b11 : 2'b10;
    m_vx = 10'd1 + {8'd0, l[10:9]};
    m_vy = 9'd12 - {7'd0, l[12:11]};
`else
    m_x  = 10'd320;
    m_dx = 2'b11;
    m_vx = 10'd2;
    m_vy = 9'd12;
`endif
    m_y    = 9'd470;
    m_dy   = 2'b10;
    m_grav = 0;
    exp_q.push_back(pack(16'(c), K_LAUNCH, m_x, m_y, m_vx, m_vy, m_dx, m_dy, 1'b0, 1'b0));
    m_hit = 1'b0;
  endtask

  // n expected strobes every 4 cycles from c0, with gravity every 2nd strobe
  task automatic exp_moves(input int c0, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pack(16'(c0 + 4 * i), K_MOVE, m_x, m_y, m_vx, m_vy, m_dx, m_dy, m_hit, 1'b1));
      if (m_grav == 1) begin
        m_grav = 0;
        if (m_dy == 2'b10) begin
          if (m_vy > 9'd1) m_vy = m_vy - 9'd1;
          else             m_dy = 2'b11;
        end else if (m_vy < 9'd15) begin
          m_vy = m_vy + 9'd1;
        end
      end else begin
        m_grav++;
      end
    end
  endtask

  task automatic exp_done(input int c, input logic h);
    m_hit = h;
    exp_q.push_back(pack(16'(c), K_DONE, m_x, m_y, m_vx, m_vy, 2'b00, 2'b00, h, 1'b0));
  endtask

  // monitor: every strobe the DUT presents is matched against the queue head
  always @(negedge clk) begin
    if (objRst === 1'b1 || moveclk === 1'b1 || done === 1'b1) begin
      if (objRst && !moveclk && !done)      mon_kind = K_LAUNCH;
      else if (moveclk && !objRst && !done) mon_kind = K_MOVE;
      else if (done && !objRst && !moveclk) mon_kind = K_DONE;
      else                                  mon_kind = 2'd0;
      mon_act = pack(cyc[15:0], mon_kind, initPosX, initPosY, vx, vy, dx, dy, hit, active);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got=%h (cyc=%0d kind=%0d)", mon_act, cyc, mon_kind);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL event cyc=%0d got=%h want=%h", cyc, mon_act, mon_exp);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst    = 1'b1;
    sliced = 1'b0;
    posx   = 10'd320;
    posy   = 9'd240;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset values
    check("rst_moveclk", moveclk, 0);
    check("rst_objRst", objRst, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_active", active, 0);
    check("rst_vx", vx, 0);
    check("rst_vy", vy, 0);
    check("rst_dx", dx, 0);
    check("rst_dy", dy, 0);
    check("rst_initPosX", initPosX, 320);
    check("rst_initPosY", initPosY, 470);
    check("rst_state", state_dbg, 0);

    // flight 1: launch on the 3rd tick, long flight through apex to saturation
    exp_launch(12);
    exp_moves(17, 56);
    rst = 1'b0;
`ifndef LAUNCHER_RANDOM_EN
    wait_cyc(22);
    check("vy_after_2nd_strobe", vy, 11);
    check("dy_rising", dy, 2'b10);
    wait_cyc(110);
    check("apex_dy", dy, 2'b11);
    check("apex_vy", vy, 1);
`endif
    wait_cyc(238);
    check("vy_saturated", vy, 15);
    check("dy_falling", dy, 2'b11);
    posy = 9'd466;
    exp_done(241, 1'b0);
    wait_cyc(242);
    check("exit_dx_frozen", dx, 0);
    check("exit_dy_frozen", dy, 0);
    check("exit_hit", hit, 0);
    posy = 9'd240;

    // flight 2: slice between ticks
    exp_launch(253);
    exp_moves(258, 3);
    wait_cyc(267);
    sliced = 1'b1;
    exp_done(268, 1'b1);
    wait_cyc(275);
    check("slice_hit_held", hit, 1);
    check("idle_active", active, 0);
    sliced = 1'b0;

    // flight 3: reset mid-flight, then relaunch after three ticks
    exp_launch(278);
    exp_moves(283, 2);
    wait_cyc(289);
    check("fly_active", active, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dx", dx, 0);
    check("midrst_vx", vx, 0);
    check("midrst_active", active, 0);
    check("midrst_state", state_dbg, 0);
    exp_launch(12);
    exp_moves(17, 1);
    rst = 1'b0;
    wait_cyc(19);

    check("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // run bound
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
